// File: rtl/omega_conf_bus_writer_if.sv
// ---------------------------------------------------------------------------
// omega_conf_bus_writer_if
//   Bundles the session control, config-word stream and conf-bus outputs of
//   omega_conf_bus_writer.
//
//   Handshake: a config word transfers on a rising clk edge where
//   s_valid & s_ready are both 1. The producer holds s_sw/s_stage/s_data
//   stable while s_valid is 1 and s_ready is 0. s_ready never depends on
//   s_valid.
//
//   Signals
//     start, num_words             session control (master -> slave)
//     s_valid, s_sw, s_stage,
//     s_data                       config word stream (master -> slave)
//     s_ready                      stream back-pressure (slave -> master)
//     net_conf_bus_out             registered 64-bit bus beat
//     busy, done, err              session status
//     dbg_state                    FSM state for observation
//   Modports: master (word producer / bench), slave (the writer).
// ---------------------------------------------------------------------------
interface omega_conf_bus_writer_if #(
  parameter int CONF_W = 2
);
  logic              start;
  logic [7:0]        num_words;
  logic              s_valid;
  logic              s_ready;
  logic [13:0]       s_sw;
  logic [7:0]        s_stage;
  logic [CONF_W-1:0] s_data;
  logic [63:0]       net_conf_bus_out;
  logic              busy;
  logic              done;
  logic              err;
  logic [1:0]        dbg_state;

  modport master (
    output start, num_words, s_valid, s_sw, s_stage, s_data,
    input  s_ready, net_conf_bus_out, busy, done, err, dbg_state
  );

  modport slave (
    input  start, num_words, s_valid, s_sw, s_stage, s_data,
    output s_ready, net_conf_bus_out, busy, done, err, dbg_state
  );
endinterface

// File: rtl/omega_conf_bus_writer.sv
// ---------------------------------------------------------------------------
// omega_conf_bus_writer
//   Producer end of the omega-network configuration bus. A session starts on
//   a start pulse in IDLE, accepts num_words config words over a
//   valid/ready stream, emits one registered 64-bit beat per word, flushes
//   for DRAIN+1 cycles so the last beat reaches the end of the switch
//   daisy chain, then pulses done.
//
//   Beat format: [63]=valid [62]=parity/0 [61:48]=sw [47:40]=stage
//                [39:0]=data zero-extended. Non-beat cycles drive 64'h0.
//
//   Ports
//     clk     rising-edge clock
//     rst     asynchronous, active-low reset
//     bus_if  omega_conf_bus_writer_if.slave (stream, control, status)
//
//   Build option: define OMEGA_CONF_WRITER_PARITY_EN to drive bit[62] with
//   even parity over bits[61:0] of each valid beat; otherwise bit[62]=0.
// ---------------------------------------------------------------------------
module omega_conf_bus_writer #(
  parameter int NUM_SW = 6,
  parameter int CONF_W = 2,
  parameter int DRAIN  = 6
) (
  input logic                     clk,
  input logic                     rst,
  omega_conf_bus_writer_if.slave  bus_if
);

  localparam int DW = (DRAIN < 1) ? 1 : $clog2(DRAIN + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [7:0]     r_cnt;
  logic [DW-1:0]  r_drain;
  logic           r_err;
  logic [63:0]    r_bus;

  logic           w_xfer;
  logic           w_last;
  logic           w_legal;
  logic           w_start_ok;
  logic           w_par;
  logic [39:0]    w_data_ext;
  logic [63:0]    w_beat;

  // Beat assembly and handshake decode.
  always_comb begin
    w_data_ext             = '0;
    w_data_ext[CONF_W-1:0] = bus_if.s_data;
    w_xfer     = (r_state == ST_SEND) && bus_if.s_valid;
    w_last     = w_xfer && (r_cnt == 8'd1);
    w_start_ok = (r_state == ST_IDLE) && bus_if.start;
    w_legal    = (bus_if.s_sw != 14'd0) && (bus_if.s_sw <= 14'(NUM_SW));
`ifdef OMEGA_CONF_WRITER_PARITY_EN
    // Even parity: with valid=1 the XOR over all 64 bits comes out 1.
    w_par = ^{bus_if.s_sw, bus_if.s_stage, w_data_ext};
`else
    w_par = 1'b0;
`endif
    w_beat = {1'b1, w_par, bus_if.s_sw, bus_if.s_stage, w_data_ext};
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus_if.start) begin
          w_next = (bus_if.num_words != 8'd0) ? ST_SEND : ST_DONE;
        end
      end
      ST_SEND: begin
        if (w_last) w_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        // The first FLUSH cycle carries the last beat; DRAIN zero cycles follow.
        if (r_drain == '0) w_next = ST_DONE;
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= 8'd0;
      r_drain <= '0;
      r_err   <= 1'b0;
      r_bus   <= 64'h0;
    end else begin
      if (w_start_ok) begin
        r_cnt <= bus_if.num_words;
      end else if (w_xfer) begin
        r_cnt <= r_cnt - 8'd1;
      end

      if (w_last) begin
        r_drain <= DW'(DRAIN);
      end else if ((r_state == ST_FLUSH) && (r_drain != '0)) begin
        r_drain <= r_drain - 1'b1;
      end

      // err clears only on an accepted start; illegal words set it.
      if (w_start_ok) begin
        r_err <= 1'b0;
      end else if (w_xfer && !w_legal) begin
        r_err <= 1'b1;
      end

      // Illegal words are consumed but leave the bus all-zero.
      r_bus <= (w_xfer && w_legal) ? w_beat : 64'h0;
    end
  end

  assign bus_if.s_ready          = (r_state == ST_SEND);
  assign bus_if.busy             = (r_state != ST_IDLE);
  assign bus_if.done             = (r_state == ST_DONE);
  assign bus_if.err              = r_err;
  assign bus_if.net_conf_bus_out = r_bus;
  assign bus_if.dbg_state        = r_state;

endmodule

// File: tb/tb_omega_conf_bus_writer.sv
// ---------------------------------------------------------------------------
// tb_omega_conf_bus_writer
//   Directed bench for omega_conf_bus_writer (NUM_SW=6, CONF_W=2, DRAIN=6).
//   Drivers push expected beats / done cycles into queues at handshake time;
//   the monitor compares every cycle against those queues.
// ---------------------------------------------------------------------------
module tb_omega_conf_bus_writer;

  localparam int NUM_SW = 6;
  localparam int CONF_W = 2;
  localparam int DRAIN  = 6;

  logic clk;
  logic rst;
  int   cyc;
  int   n_vec;
  int   n_err;

  logic [63:0] exp_q[$];
  int          done_q[$];
  logic        pend;

  omega_conf_bus_writer_if #(.CONF_W(CONF_W)) bus_if ();

  omega_conf_bus_writer #(
    .NUM_SW (NUM_SW),
    .CONF_W (CONF_W),
    .DRAIN  (DRAIN)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus_if)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  function automatic void chk(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endfunction

  // Table beats are written without the parity bit; add it for parity builds.
  function automatic logic [63:0] add_par(input logic [63:0] b);
    logic [63:0] r;
    r = b;
`ifdef OMEGA_CONF_WRITER_PARITY_EN
    if (r[63]) r[62] = ^r[61:0];
`endif
    return r;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst) begin
      pend = 1'b0;
      exp_q.delete();
      done_q.delete();
    end else begin
      if (pend) begin
        if (exp_q.size() == 0) fail_now("beat_queue_empty");
        else chk("beat", bus_if.net_conf_bus_out, exp_q.pop_front());
      end else begin
        chk("idle_bus", bus_if.net_conf_bus_out, 64'h0);
      end
      if (bus_if.done) begin
        if (done_q.size() == 0) fail_now("unexpected_done");
        else chk("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
      end
      pend = bus_if.s_valid & bus_if.s_ready;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_session(input logic [7:0] n);
    bus_if.start     = 1'b1;
    bus_if.num_words = n;
    @(negedge clk);
    if (n == 8'd0) done_q.push_back(cyc + 1);
    step();
    bus_if.start = 1'b0;
  endtask

  task automatic send_word(input logic [13:0] sw, input logic [7:0] st,
                           input logic [1:0] d, input logic [63:0] exp,
                           input bit last);
    bit got;
    got           = 1'b0;
    bus_if.s_valid = 1'b1;
    bus_if.s_sw    = sw;
    bus_if.s_stage = st;
    bus_if.s_data  = d;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (bus_if.s_ready) begin
        exp_q.push_back(add_par(exp));
        if (last) done_q.push_back(cyc + DRAIN + 2);
        got = 1'b1;
      end
      step();
    end
    bus_if.s_valid = 1'b0;
    if (!got) fail_now("handshake_timeout");
  endtask

  task automatic wait_session_end();
    for (int i = 0; i < 100 && done_q.size() != 0; i++) step();
    if (done_q.size() != 0) fail_now("done_timeout");
    @(negedge clk);
    chk("busy_after_done", 64'(bus_if.busy), 64'h0);
    chk("ready_after_done", 64'(bus_if.s_ready), 64'h0);
    step();
  endtask

  // ---------------- stimulus ----------------
  logic [63:0] burst_exp [6];
  logic [7:0]  burst_stg [6];

  initial begin
    cyc   = 0;
    n_vec = 0;
    n_err = 0;
    pend  = 1'b0;
    rst   = 1'b0;
    bus_if.start     = 1'b0;
    bus_if.num_words = 8'd0;
    bus_if.s_valid   = 1'b0;
    bus_if.s_sw      = 14'd0;
    bus_if.s_stage   = 8'd0;
    bus_if.s_data    = '0;

    burst_exp[0] = 64'h8001_0100_0000_0001;
    burst_exp[1] = 64'h8002_0100_0000_0001;
    burst_exp[2] = 64'h8003_0200_0000_0001;
    burst_exp[3] = 64'h8004_0200_0000_0001;
    burst_exp[4] = 64'h8005_0300_0000_0001;
    burst_exp[5] = 64'h8006_0300_0000_0001;
    burst_stg[0] = 8'd1; burst_stg[1] = 8'd1; burst_stg[2] = 8'd2;
    burst_stg[3] = 8'd2; burst_stg[4] = 8'd3; burst_stg[5] = 8'd3;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_bus",   bus_if.net_conf_bus_out, 64'h0);
    chk("rst_busy",  64'(bus_if.busy),    64'h0);
    chk("rst_done",  64'(bus_if.done),    64'h0);
    chk("rst_err",   64'(bus_if.err),     64'h0);
    chk("rst_ready", 64'(bus_if.s_ready), 64'h0);
    step();
    rst = 1'b1;
    step();

    // 1: reset mid-SEND aborts at once, no done afterwards
    start_session(8'd4);
    send_word(14'd1, 8'd1, 2'b01, 64'h8001_0100_0000_0001, 1'b0);
    send_word(14'd2, 8'd1, 2'b01, 64'h8002_0100_0000_0001, 1'b0);
    rst = 1'b0;
    #1;
    chk("midrst_bus",   bus_if.net_conf_bus_out, 64'h0);
    chk("midrst_busy",  64'(bus_if.busy),    64'h0);
    chk("midrst_ready", 64'(bus_if.s_ready), 64'h0);
    step();
    step();
    rst = 1'b1;
    repeat (12) step();

    // 2: back-to-back burst, then a start during FLUSH that must be ignored
    start_session(8'd6);
    for (int i = 0; i < 6; i++)
      send_word(14'(i + 1), burst_stg[i], 2'b01, burst_exp[i], i == 5);
    step();
    bus_if.start     = 1'b1;
    bus_if.num_words = 8'd3;
    step();
    bus_if.start = 1'b0;
    wait_session_end();
    repeat (3) step();
    chk("flush_start_ignored", 64'(bus_if.busy), 64'h0);

    // 3: gaps in s_valid
    start_session(8'd3);
    send_word(14'd2, 8'd4,   2'b10, 64'h8002_0400_0000_0002, 1'b0);
    step();
    send_word(14'd5, 8'd0,   2'b11, 64'h8005_0000_0000_0003, 1'b0);
    step();
    step();
    send_word(14'd6, 8'hff,  2'b00, 64'h8006_ff00_0000_0000, 1'b1);
    wait_session_end();

    // 4: illegal switch numbers
    start_session(8'd3);
    send_word(14'd0, 8'd1, 2'b01, 64'h0, 1'b0);
    send_word(14'd7, 8'd2, 2'b10, 64'h0, 1'b0);
    @(negedge clk);
    chk("err_set", 64'(bus_if.err), 64'h1);
    step();
    send_word(14'd4, 8'd1, 2'b11, 64'h8004_0100_0000_0003, 1'b1);
    wait_session_end();
    chk("err_held", 64'(bus_if.err), 64'h1);

    // 5: zero-length session
    start_session(8'd0);
    wait_session_end();
    chk("err_held_zero", 64'(bus_if.err), 64'h0);

    // 6: parity beat (bits[62:0] XOR to 0 in either build)
    start_session(8'd1);
    send_word(14'd3, 8'd5, 2'b11, 64'h8003_0500_0000_0003, 1'b1);
    chk("par_xor", 64'(^bus_if.net_conf_bus_out[62:0]), 64'h0);
    chk("par_valid", 64'(bus_if.net_conf_bus_out[63]), 64'h1);
    wait_session_end();

    repeat (4) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "timeout");
  end

endmodule
